// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for a 1-byte I2C engine.
// Optional WAIT watchdog is built only when I2C_ARB_TIMEOUT_EN is defined.
module i2c_req_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_req_rnw,
  input  logic [5:0]  i_req_dev_addr,
  input  logic [15:0] i_req_word_addr,
  input  logic [15:0] i_req_wr_data,
  output logic [1:0]  o_grant,
  output logic [1:0]  o_done,
  output logic [7:0]  o_rd_data,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_wr_start_flag,
  output logic        o_rd_start_flag,
  output logic [2:0]  o_device_addr,
  output logic [7:0]  o_word_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_eng_done,
  input  logic [7:0]  i_eng_rd_data,
  input  logic        i_eng_ack_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic       win_id;
  logic       id_q;
  logic       rnw_q;
  logic       last_grant;
  logic [2:0] dev_q;
  logic [7:0] word_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       timeout_hit;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign timeout_hit = (wd_cnt == (TIMEOUT_CYCLES - 16'd1));
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // On contention the requester that was not granted last wins.
  always_comb begin
    win_id = 1'b0;
    case (i_req)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_grant;
      default: win_id = 1'b0;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      id_q       <= 1'b0;
      rnw_q      <= 1'b0;
      last_grant <= 1'b1;
      dev_q      <= 3'd0;
      word_q     <= 8'd0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
      err_q      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_cnt     <= 16'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            id_q    <= win_id;
            rnw_q   <= i_req_rnw[win_id];
            dev_q   <= win_id ? i_req_dev_addr[5:3] : i_req_dev_addr[2:0];
            word_q  <= win_id ? i_req_word_addr[15:8] : i_req_word_addr[7:0];
            wdata_q <= win_id ? i_req_wr_data[15:8] : i_req_wr_data[7:0];
          end
        end
        ST_START: begin
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt <= 16'd0;
`endif
        end
        ST_WAIT: begin
          // Read data is only meaningful for an acknowledged read.
          if (i_eng_done) begin
            rdata_q <= (rnw_q && !i_eng_ack_err) ? i_eng_rd_data : 8'h00;
            err_q   <= i_eng_ack_err;
          end else if (timeout_hit) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          last_grant <= id_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next      = state;
    o_grant         = 2'b00;
    o_done          = 2'b00;
    o_rd_data       = 8'h00;
    o_err           = 1'b0;
    o_wr_start_flag = 1'b0;
    o_rd_start_flag = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|i_req) state_next = ST_START;
      end
      ST_START: begin
        o_grant[id_q]   = 1'b1;
        o_rd_start_flag = rnw_q;
        o_wr_start_flag = ~rnw_q;
        state_next      = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_eng_done || timeout_hit) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done[id_q] = 1'b1;
        o_rd_data    = rdata_q;
        o_err        = err_q;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_busy        = (state != ST_IDLE);
  assign o_device_addr = dev_q;
  assign o_word_addr   = word_q;
  assign o_wr_data     = wdata_q;

endmodule
